// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO with registered read port, occupancy count,
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module sync_fifo_ctrl #(
  parameter int DATA_WD = 8,
  parameter int FIFO_DP = 8,
  parameter int PTR_WD  = $clog2(FIFO_DP) + 1,
  parameter int AF_LVL  = FIFO_DP - 2,
  parameter int AE_LVL  = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               FLUSH,
  input  logic [DATA_WD-1:0] WR_DATA,
  input  logic               W_INC,
  input  logic               R_INC,
  output logic [DATA_WD-1:0] RD_DATA,
  output logic               RD_VALID,
  output logic               FULL,
  output logic               EMPTY,
  output logic               ALMOST_FULL,
  output logic               ALMOST_EMPTY,
  output logic [PTR_WD-1:0]  COUNT,
  output logic               OVERFLOW,
  output logic               UNDERFLOW
);

  localparam int AW = PTR_WD - 1;
  localparam logic [PTR_WD-1:0] DEPTH_C = PTR_WD'(FIFO_DP);
  localparam logic [PTR_WD-1:0] AF_C    = PTR_WD'(AF_LVL);
  localparam logic [PTR_WD-1:0] AE_C    = PTR_WD'(AE_LVL);
  localparam logic [PTR_WD-1:0] ONE_C   = PTR_WD'(1);

  logic [DATA_WD-1:0] mem_q [FIFO_DP];

  logic [PTR_WD-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_WD-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_WD-1:0]  count_q, count_d;
  logic [DATA_WD-1:0] rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               ovf_q, ovf_d;
  logic               udf_q, udf_d;
  logic               wr_acc, rd_acc;
  logic [AW-1:0]      wr_addr, rd_addr;

  // Status flags decode from the registered count only, so they never see inputs.
  assign FULL         = (count_q == DEPTH_C);
  assign EMPTY        = (count_q == '0);
  assign ALMOST_FULL  = (count_q >= AF_C);
  assign ALMOST_EMPTY = (count_q <= AE_C);

  assign COUNT     = count_q;
  assign RD_DATA   = rd_data_q;
  assign RD_VALID  = rd_valid_q;
  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = udf_q;

  assign wr_addr = wr_ptr_q[AW-1:0];
  assign rd_addr = rd_ptr_q[AW-1:0];

  // Acceptance gated on current state; flush overrides all requests.
  always_comb begin
    wr_acc     = W_INC & ~FULL  & ~FLUSH;
    rd_acc     = R_INC & ~EMPTY & ~FLUSH;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    ovf_d      = ovf_q | (W_INC & FULL);
    udf_d      = udf_q | (R_INC & EMPTY);
    if (FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ONE_C;
      if (rd_acc) begin
        rd_ptr_d   = rd_ptr_q + ONE_C;
        rd_data_d  = mem_q[rd_addr];
        rd_valid_d = 1'b1;
      end
      // Count tracks wr_ptr - rd_ptr; simultaneous accepts cancel.
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  // Storage array; not reset, contents are only reachable through the pointers.
  always_ff @(posedge CLK) begin
    if (wr_acc) mem_q[wr_addr] <= WR_DATA;
  end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed testbench for sync_fifo_ctrl at default parameters (depth 8, AF 6, AE 2).
module tb_sync_fifo_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       FLUSH = 1'b0;
  logic [7:0] WR_DATA = '0;
  logic       W_INC = 1'b0;
  logic       R_INC = 1'b0;
  logic [7:0] RD_DATA;
  logic       RD_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW;
  logic [3:0] COUNT;

  int errs = 0;
  int checks = 0;

  sync_fifo_ctrl #(.DATA_WD(8), .FIFO_DP(8), .AF_LVL(6), .AE_LVL(2)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .WR_DATA(WR_DATA), .W_INC(W_INC),
    .R_INC(R_INC), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .FULL(FULL),
    .EMPTY(EMPTY), .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY),
    .COUNT(COUNT), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_flush();
    FLUSH = 1'b1; W_INC = 1'b0; R_INC = 1'b0;
    tick();
    FLUSH = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick(); tick();
    checks++; if (COUNT !== 4'd0) begin errs++; $display("FAIL reset_count got=%0d exp=0", COUNT); end
    checks++; if ({EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL} !== 4'b1010) begin errs++; $display("FAIL reset_flags got=%b exp=1010", {EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL}); end
    checks++; if ({RD_VALID, OVERFLOW, UNDERFLOW} !== 3'b000 || RD_DATA !== 8'h00) begin errs++; $display("FAIL reset_outs vld/ovf/udf=%b data=%h exp=000/00", {RD_VALID, OVERFLOW, UNDERFLOW}, RD_DATA); end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      W_INC = 1'b1; WR_DATA = 8'(i);
      tick();
      checks++; if (COUNT !== 4'(i)) begin errs++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, COUNT, i); end
      checks++; if ({ALMOST_EMPTY, ALMOST_FULL, FULL, EMPTY} !== {(i <= 2), (i >= 6), (i == 8), 1'b0}) begin
        errs++; $display("FAIL fill_flags[%0d] ae/af/full/empty got=%b exp=%b", i, {ALMOST_EMPTY, ALMOST_FULL, FULL, EMPTY}, {(i <= 2), (i >= 6), (i == 8), 1'b0}); end
    end
    WR_DATA = 8'h09;
    tick();
    W_INC = 1'b0;
    checks++; if (COUNT !== 4'd8 || OVERFLOW !== 1'b1) begin errs++; $display("FAIL fill_overflow count=%0d ovf=%b exp=8/1", COUNT, OVERFLOW); end
  endtask

  task automatic test_drain();
    R_INC = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++; if (RD_VALID !== 1'b1 || RD_DATA !== 8'(i)) begin errs++; $display("FAIL drain[%0d] vld=%b data=%h exp=1/%h", i, RD_VALID, RD_DATA, 8'(i)); end
      checks++; if (COUNT !== 4'(8 - i) || EMPTY !== (i == 8)) begin errs++; $display("FAIL drain_cnt[%0d] count=%0d empty=%b exp=%0d/%b", i, COUNT, EMPTY, 8 - i, (i == 8)); end
    end
    tick();
    R_INC = 1'b0;
    checks++; if (RD_VALID !== 1'b0 || RD_DATA !== 8'h08 || UNDERFLOW !== 1'b1) begin
      errs++; $display("FAIL drain_underflow vld=%b data=%h udf=%b exp=0/08/1", RD_VALID, RD_DATA, UNDERFLOW); end
    do_flush();
    checks++; if (OVERFLOW !== 1'b0 || UNDERFLOW !== 1'b0) begin errs++; $display("FAIL drain_flush_clear ovf=%b udf=%b exp=0/0", OVERFLOW, UNDERFLOW); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) begin
      W_INC = 1'b1; WR_DATA = 8'(8'h10 + i);
      tick();
    end
    R_INC = 1'b1;
    for (int k = 0; k < 17; k++) begin
      WR_DATA = 8'(8'h13 + k);
      tick();
      checks++; if (RD_VALID !== 1'b1 || RD_DATA !== 8'(8'h10 + k)) begin errs++; $display("FAIL wrap_data[%0d] vld=%b data=%h exp=1/%h", k, RD_VALID, RD_DATA, 8'(8'h10 + k)); end
      checks++; if (COUNT !== 4'd3 || FULL !== 1'b0 || EMPTY !== 1'b0) begin errs++; $display("FAIL wrap_state[%0d] count=%0d full=%b empty=%b exp=3/0/0", k, COUNT, FULL, EMPTY); end
    end
    W_INC = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (RD_DATA !== 8'(8'h21 + k) || COUNT !== 4'(2 - k)) begin errs++; $display("FAIL wrap_tail[%0d] data=%h count=%0d exp=%h/%0d", k, RD_DATA, COUNT, 8'(8'h21 + k), 2 - k); end
    end
    R_INC = 1'b0;
    tick();
  endtask

  task automatic test_simul();
    W_INC = 1'b1;
    for (int i = 0; i < 8; i++) begin
      WR_DATA = 8'(8'h30 + i);
      tick();
    end
    checks++; if (FULL !== 1'b1) begin errs++; $display("FAIL simul_full got=%b exp=1", FULL); end
    R_INC = 1'b1; WR_DATA = 8'hEE;
    tick();
    W_INC = 1'b0; R_INC = 1'b0;
    checks++; if (COUNT !== 4'd7 || OVERFLOW !== 1'b1 || RD_DATA !== 8'h30 || RD_VALID !== 1'b1) begin
      errs++; $display("FAIL simul_full_rw count=%0d ovf=%b data=%h vld=%b exp=7/1/30/1", COUNT, OVERFLOW, RD_DATA, RD_VALID); end
    do_flush();
    W_INC = 1'b1; R_INC = 1'b1; WR_DATA = 8'h55;
    tick();
    W_INC = 1'b0; R_INC = 1'b0;
    checks++; if (COUNT !== 4'd1 || UNDERFLOW !== 1'b1 || RD_VALID !== 1'b0) begin
      errs++; $display("FAIL simul_empty_rw count=%0d udf=%b vld=%b exp=1/1/0", COUNT, UNDERFLOW, RD_VALID); end
    R_INC = 1'b1;
    tick();
    R_INC = 1'b0;
    checks++; if (RD_DATA !== 8'h55 || EMPTY !== 1'b1) begin errs++; $display("FAIL simul_empty_word data=%h empty=%b exp=55/1", RD_DATA, EMPTY); end
    do_flush();
  endtask

  task automatic test_flush();
    W_INC = 1'b1;
    for (int i = 0; i < 9; i++) begin
      WR_DATA = 8'(8'h40 + i);
      tick();
    end
    W_INC = 1'b0; R_INC = 1'b1;
    tick(); tick(); tick();
    checks++; if (COUNT !== 4'd5 || OVERFLOW !== 1'b1 || RD_DATA !== 8'h42 || RD_VALID !== 1'b1) begin
      errs++; $display("FAIL flush_setup count=%0d ovf=%b data=%h vld=%b exp=5/1/42/1", COUNT, OVERFLOW, RD_DATA, RD_VALID); end
    FLUSH = 1'b1; W_INC = 1'b1; WR_DATA = 8'h99;
    tick();
    FLUSH = 1'b0; W_INC = 1'b0; R_INC = 1'b0;
    checks++; if (COUNT !== 4'd0 || EMPTY !== 1'b1 || OVERFLOW !== 1'b0 || RD_VALID !== 1'b0 || RD_DATA !== 8'h42) begin
      errs++; $display("FAIL flush_prio count=%0d empty=%b ovf=%b vld=%b data=%h exp=0/1/0/0/42", COUNT, EMPTY, OVERFLOW, RD_VALID, RD_DATA); end
  endtask

  task automatic test_async_reset();
    W_INC = 1'b1;
    for (int i = 0; i < 4; i++) begin
      WR_DATA = 8'(8'h60 + i);
      tick();
    end
    W_INC = 1'b0;
    checks++; if (COUNT !== 4'd4) begin errs++; $display("FAIL arst_setup count=%0d exp=4", COUNT); end
    #2 RST = 1'b1;
    #1;
    checks++; if (COUNT !== 4'd0 || RD_DATA !== 8'h00 || EMPTY !== 1'b1) begin
      errs++; $display("FAIL arst_async count=%0d data=%h empty=%b exp=0/00/1", COUNT, RD_DATA, EMPTY); end
    #1 RST = 1'b0;
    W_INC = 1'b1; WR_DATA = 8'hA5;
    tick();
    W_INC = 1'b0; R_INC = 1'b1;
    tick();
    R_INC = 1'b0;
    checks++; if (RD_DATA !== 8'hA5 || RD_VALID !== 1'b1 || COUNT !== 4'd0) begin
      errs++; $display("FAIL arst_after data=%h vld=%b count=%0d exp=A5/1/0", RD_DATA, RD_VALID, COUNT); end
    tick();
    checks++; if (RD_VALID !== 1'b0 || RD_DATA !== 8'hA5) begin errs++; $display("FAIL arst_strobe vld=%b data=%h exp=0/A5", RD_VALID, RD_DATA); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simul();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Single-clock, parametrised FIFO combining storage, pointer control, occupancy tracking and status flags in one block. It is the single-clock successor to the split memory/pointer async FIFO and is used where producer and consumer share a clock, for example as the UART TX/RX byte buffers and the register-file command queue. It adds a programmable almost-full and almost-empty threshold, an occupancy count, a registered read port with a valid strobe, a synchronous flush, and sticky overflow/underflow error flags.

## Interface
- DATA_WD, 8: data word width in bits.
- FIFO_DP, 8: depth in words. Must be a power of two and ≥ 2.
- PTR_WD, $clog2(FIFO_DP)+1: pointer width, including one wrap bit. Derived; do not override.
- AF_LVL, FIFO_DP-2: ALMOST_FULL asserts when the count is ≥ AF_LVL. Range 1..FIFO_DP.
- AE_LVL, 2: ALMOST_EMPTY asserts when the count is ≤ AE_LVL. Range 0..FIFO_DP-1.
- CLK  in  1: single clock. All state updates on the rising edge.
- RST  in  1: asynchronous, active-high reset.
- FLUSH  in  1: synchronous clear of FIFO state.
- WR_DATA  in  DATA_WD: write data.
- W_INC  in  1: write request.
- R_INC  in  1: read request.
- RD_DATA  out  DATA_WD: registered read data.
- RD_VALID  out  1: one-cycle strobe; RD_DATA holds a newly popped word.
- FULL  out  1: count == FIFO_DP.
- EMPTY  out  1: count == 0.
- ALMOST_FULL  out  1: count ≥ AF_LVL.
- ALMOST_EMPTY  out  1: count ≤ AE_LVL.
- COUNT  out  PTR_WD: current occupancy, 0..FIFO_DP.
- OVERFLOW  out  1: sticky; a write was attempted while FULL.
- UNDERFLOW  out  1: sticky; a read was attempted while EMPTY.

## Operation
- **Storage:** FIFO_DP × DATA_WD register array, addressed by wr_ptr[PTR_WD-2:0] and rd_ptr[PTR_WD-2:0]. The memory is not reset.
- **Write acceptance:** wr_acc = W_INC & ~FULL & ~FLUSH.
  - On wr_acc: MEM[wr_addr] <= WR_DATA, and wr_ptr increments.
- **Read acceptance:** rd_acc = R_INC & ~EMPTY & ~FLUSH.
  - On rd_acc: RD_DATA <= MEM[rd_addr], rd_ptr increments, and RD_VALID <= 1.
  - Otherwise RD_VALID <= 0 and RD_DATA holds its value.
- **Gating is on current state only.**
  - When FULL with both W_INC and R_INC: the read is accepted, the write is rejected, and OVERFLOW sets.
  - When EMPTY with both: the write is accepted, the read is rejected, and UNDERFLOW sets.
  - There is no write-to-read bypass.
- **Pointer wrap:** pointers wrap naturally modulo 2^PTR_WD. The MSB distinguishes full from empty when the address bits are equal.
- **COUNT update:**
  - COUNT+1 on write only.
  - COUNT-1 on read only.
  - Unchanged when both or neither are accepted.
  - COUNT must always equal wr_ptr - rd_ptr, computed modulo 2^PTR_WD.
- **Flags:** FULL, EMPTY, ALMOST_FULL and ALMOST_EMPTY decode combinationally from the registered COUNT. They are therefore glitch-free relative to CLK and reflect state after the last edge.
- **Sticky errors:**
  - OVERFLOW sets on W_INC & FULL & ~FLUSH.
  - UNDERFLOW sets on R_INC & EMPTY & ~FLUSH.
  - Both hold until FLUSH or RST.
- **FLUSH** (takes priority over all requests in the same cycle):
  - Pointers and COUNT go to 0.
  - RD_VALID, OVERFLOW and UNDERFLOW go to 0.
  - RD_DATA holds its value.
  - Memory contents are unchanged but unreachable.
- **Reset (RST = 1, asynchronous):**
  - Pointers and COUNT go to 0.
  - RD_DATA goes to 0.
  - RD_VALID, OVERFLOW and UNDERFLOW go to 0.
  - Outputs immediately show EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=0 (this assumes AF_LVL ≥ 1).
  - Reset mid-burst discards all contents. The first edge after deassertion behaves as a normal idle-state cycle.

## Timing
- **Write-to-flag latency:** 1 cycle. A write accepted at edge N updates COUNT and flags after edge N.
- **Read latency:** 1 cycle. R_INC sampled at edge N gives RD_DATA and RD_VALID=1 after edge N, held for exactly one cycle unless another read is accepted.
- **Throughput:** one write and one read per cycle sustained when neither FULL nor EMPTY.
- **Write-to-read latency:** a word written at edge N is readable (EMPTY=0) after edge N. R_INC at edge N+1 gives the data after N+1.
- **Read/write at full depth:** back-to-back full-rate read/write at COUNT = FIFO_DP-1 keeps COUNT steady with no FULL assertion.
- **Combinational paths:** none from inputs to outputs. All outputs are registered or decoded from registers.

## Test plan
Default parameters for all scenarios: DATA_WD=8, FIFO_DP=8, AF_LVL=6, AE_LVL=2.

1. **Reset and fill:** RST pulse, then write 0x01..0x08 on consecutive cycles.
   - COUNT steps 1..8.
   - ALMOST_EMPTY drops at COUNT=3.
   - ALMOST_FULL rises at COUNT=6.
   - FULL rises at COUNT=8.
   - A 9th write sets OVERFLOW, and COUNT stays 8.
2. **Drain in order:** from full, hold R_INC for 9 cycles.
   - RD_DATA is 0x01..0x08, each with RD_VALID=1, one cycle after each request.
   - EMPTY rises after the 8th read.
   - The 9th request sets UNDERFLOW, gives RD_VALID=0, and RD_DATA holds 0x08.
3. **Wrap-around:** stream 20 words 0x10..0x23 with simultaneous read and write, starting at COUNT=3.
   - Data is returned in order.
   - COUNT stays 3 throughout.
   - Pointers wrap at least twice.
   - FULL and EMPTY never assert.
4. **Simultaneous edge cases:**
   - At FULL with W_INC=R_INC=1: COUNT becomes 7 and OVERFLOW sets.
   - At EMPTY with both: COUNT becomes 1, UNDERFLOW sets, and RD_VALID=0.
5. **FLUSH priority:** at COUNT=5 with OVERFLOW=1, assert FLUSH together with W_INC and R_INC.
   - Next cycle: COUNT=0, EMPTY=1, OVERFLOW=0, RD_VALID=0, and RD_DATA is unchanged.
6. **Asynchronous reset mid-operation:** assert RST between edges at COUNT=4.
   - Outputs go to their reset values with no clock edge: COUNT=0, RD_DATA=0x00, EMPTY=1.
   - After release, a write of 0xA5 followed by a read returns 0xA5.
